// File: rtl/fc_weight_loader.sv
// FC weight loader: streams packed weight words into a shadow buffer and commits
// them to the active weight_matrix_o register in a single atomic update.
module fc_weight_loader #(
  parameter int MP_BITWIDTH    = 8,
  parameter int FC_INPUT_SIZE  = 4,
  parameter int FC_OUTPUT_SIZE = 2,
  parameter int WORD_W         = 32,
  localparam int W_TOTAL   = MP_BITWIDTH * FC_INPUT_SIZE * FC_OUTPUT_SIZE,
  localparam int NUM_WORDS = (W_TOTAL + WORD_W - 1) / WORD_W,
  localparam int PAD_W     = NUM_WORDS * WORD_W,
  localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [WORD_W-1:0]  wr_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   load_cnt_o,
  output logic               weight_valid_o,
  output logic [W_TOTAL-1:0] weight_matrix_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAD_W-1:0]   shadow_q, shadow_d;
  logic [W_TOTAL-1:0] weight_q, weight_d;
  logic               wvalid_q, wvalid_d;
  logic               done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      weight_q <= '0;
      wvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      weight_q <= weight_d;
      wvalid_q <= wvalid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    weight_d = weight_q;
    wvalid_d = wvalid_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        // A restart wins over a same-cycle transfer, which is dropped.
        if (start_i) begin
          cnt_d = '0;
        end else if (wr_valid_i) begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (cnt_q == CNT_W'(k)) shadow_d[PAD_W-1-k*WORD_W -: WORD_W] = wr_data_i;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_WORDS - 1)) state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // Padding bits of the final word sit below W_TOTAL and are dropped here.
        weight_d = shadow_q[PAD_W-1 -: W_TOTAL];
        wvalid_d = 1'b1;
        done_d   = 1'b1;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_ready_o      = (state_q == S_LOAD);
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = done_q;
  assign load_cnt_o      = cnt_q;
  assign weight_valid_o  = wvalid_q;
  assign weight_matrix_o = weight_q;

endmodule
